lcd_port_arbiter: RTL and testbench

- Shares the single character-buffer port of the LCD controller (write enable, 5-bit location, 8-bit data, combinational read data) between several requesters: CPU store path, hex status dumper, message streamer.
- Grants requesters round-robin, one access at a time. Returns registered read data with a one-cycle ack.
- Supports a lock so a requester can write a whole 16-character line atomically.
- Sits between the requesters and the LCD controller.

---
 rtl/lcd_arb_pkg.sv | 15 +
 rtl/lcd_rr_picker.sv | 25 ++
 rtl/lcd_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_lcd_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared types and sizes for the LCD character-buffer port arbiter.
package lcd_arb_pkg;

  localparam int LCD_ADDR_W   = 5;
  localparam int LCD_DATA_W   = 8;
  localparam int LCD_LINE_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMPLETE,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module lcd_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Scan from lowest to highest priority so the nearest hit after 'last' wins.
  always_comb begin
    // NOTE: outputs get defaults before the loop so no path can infer a latch.
    winner = '0;
    valid  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        winner = IDX_W'((int'(last) + k) % NUM_REQ);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_port_arbiter.sv
// Round-robin arbiter sharing the LCD controller character-buffer port,
// with per-owner lock for atomic multi-character writes and a lock timeout.
module lcd_port_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = LCD_ADDR_W,
  parameter int DATA_W       = LCD_DATA_W,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      lock_timeout,
  output logic                      lcd_we,
  output logic [ADDR_W-1:0]         lcd_location,
  output logic [DATA_W-1:0]         lcd_data,
  input  logic [DATA_W-1:0]         lcd_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                lock_timeout_q, lock_timeout_d;
  logic                lcd_we_q, lcd_we_d;
  logic [ADDR_W-1:0]   lcd_location_q, lcd_location_d;
  logic [DATA_W-1:0]   lcd_data_q, lcd_data_d;
  logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  lcd_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    to_onehot      = '0;
    to_onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    state_d        = state_q;
    winner_d       = winner_q;
    last_d         = last_q;
    gnt_d          = gnt_q;
    ack_d          = '0;
    rdata_d        = rdata_q;
    lock_timeout_d = 1'b0;
    lcd_we_d       = 1'b0;
    lcd_location_d = lcd_location_q;
    lcd_data_d     = lcd_data_q;
    idle_cnt_d     = idle_cnt_q;

    unique case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (pick_valid) begin
          winner_d       = pick_idx;
          gnt_d          = to_onehot(pick_idx);
          lcd_we_d       = we[pick_idx];
          lcd_location_d = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          lcd_data_d     = wdata[int'(pick_idx)*DATA_W +: DATA_W];
          state_d        = ISSUE;
        end
      end

      // Read data is captured even on writes; it is the pre-write cell value.
      ISSUE: begin
        rdata_d = lcd_read_data;
        ack_d   = to_onehot(winner_q);
        state_d = COMPLETE;
      end

      COMPLETE: begin
        if (lock[winner_q]) begin
          idle_cnt_d = '0;
          state_d    = HOLD;
        end else begin
          last_d  = winner_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end

      HOLD: begin
        if (req[winner_q]) begin
          idle_cnt_d     = '0;
          lcd_we_d       = we[winner_q];
          lcd_location_d = addr[int'(winner_q)*ADDR_W +: ADDR_W];
          lcd_data_d     = wdata[int'(winner_q)*DATA_W +: DATA_W];
          state_d        = ISSUE;
        end else if (!lock[winner_q]) begin
          last_d  = winner_q;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          lock_timeout_d = 1'b1;
          last_d         = winner_q;
          gnt_d          = '0;
          state_d        = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      winner_q       <= '0;
      last_q         <= IDX_W'(NUM_REQ - 1);
      gnt_q          <= '0;
      ack_q          <= '0;
      rdata_q        <= '0;
      lock_timeout_q <= 1'b0;
      lcd_we_q       <= 1'b0;
      lcd_location_q <= '0;
      lcd_data_q     <= '0;
      idle_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking only, so every flop samples pre-edge values together.
      state_q        <= state_d;
      winner_q       <= winner_d;
      last_q         <= last_d;
      gnt_q          <= gnt_d;
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
      lock_timeout_q <= lock_timeout_d;
      lcd_we_q       <= lcd_we_d;
      lcd_location_q <= lcd_location_d;
      lcd_data_q     <= lcd_data_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign lock_timeout = lock_timeout_q;
  assign lcd_we       = lcd_we_q;
  assign lcd_location = lcd_location_q;
  assign lcd_data     = lcd_data_q;

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Randomised and directed bench for lcd_port_arbiter against a transaction-level
// reference model and an emulated LCD character buffer.
module tb_lcd_port_arbiter;
  import lcd_arb_pkg::*;

  localparam int N   = 3;
  localparam int AW  = LCD_ADDR_W;
  localparam int DW  = LCD_DATA_W;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, we, lock;
  logic [AW-1:0]     addr_a  [N];
  logic [DW-1:0]     wdata_a [N];
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt, ack;
  logic [DW-1:0]     rdata;
  logic              lock_timeout, lcd_we;
  logic [AW-1:0]     lcd_location;
  logic [DW-1:0]     lcd_data, lcd_read_data;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = addr_a[i];
      wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  lcd_port_arbiter #(
    .NUM_REQ      (N),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .we            (we),
    .lock          (lock),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .ack           (ack),
    .rdata         (rdata),
    .lock_timeout  (lock_timeout),
    .lcd_we        (lcd_we),
    .lcd_location  (lcd_location),
    .lcd_data      (lcd_data),
    .lcd_read_data (lcd_read_data)
  );

  // Emulated LCD character buffer: combinational read, write on clock edge.
  logic [DW-1:0] lcd_mem [32];
  logic          mem_load;

  function automatic logic [DW-1:0] seed_val(input int i);
    return (i == 3) ? 8'h5A : 8'(i * 37 + 11);
  endfunction

  assign lcd_read_data = lcd_mem[lcd_location];

  always @(posedge clk) begin
    if (mem_load) for (int i = 0; i < 32; i++) lcd_mem[i] <= seed_val(i);
    else if (lcd_we) lcd_mem[lcd_location] <= lcd_data;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port and which part of a transaction is due.
  typedef enum {P_FREE, P_BUS, P_DONE, P_KEEP} phase_t;
  phase_t        phase;
  int            owner, last_owner, idle_run;
  logic [DW-1:0] ref_mem [32];
  logic [N-1:0]  exp_gnt, exp_ack;
  logic          exp_we, exp_to;
  logic [AW-1:0] exp_loc;
  logic [DW-1:0] exp_data, exp_rdata;

  task automatic model_reset();
    phase = P_FREE; owner = -1; last_owner = N - 1; idle_run = 0;
    exp_gnt = '0; exp_ack = '0; exp_we = 1'b0; exp_to = 1'b0;
    exp_loc = '0; exp_data = '0; exp_rdata = '0;
  endtask

  function automatic int rr_first();
    for (int k = 1; k <= N; k++) if (req[(last_owner + k) % N]) return (last_owner + k) % N;
    return -1;
  endfunction

  task automatic start(input int w);
    owner = w; exp_gnt = '0; exp_gnt[w] = 1'b1;
    exp_loc = addr_a[w]; exp_data = wdata_a[w]; exp_we = we[w];
    idle_run = 0; phase = P_BUS;
  endtask

  task automatic release_port();
    last_owner = owner; owner = -1; exp_gnt = '0; phase = P_FREE;
  endtask

  task automatic model_step();
    logic was_we;
    int   w;
    was_we = exp_we; exp_we = 1'b0; exp_ack = '0; exp_to = 1'b0;
    case (phase)
      P_FREE: begin
        w = rr_first();
        if (w >= 0) start(w);
      end
      P_BUS: begin
        exp_rdata = ref_mem[exp_loc];
        if (was_we) ref_mem[exp_loc] = exp_data;
        exp_ack[owner] = 1'b1;
        phase = P_DONE;
      end
      P_DONE: begin
        if (lock[owner]) begin phase = P_KEEP; idle_run = 0; end
        else release_port();
      end
      P_KEEP: begin
        if (req[owner]) start(owner);
        else if (!lock[owner]) release_port();
        else if (idle_run == TMO - 1) begin exp_to = 1'b1; release_port(); end
        else idle_run++;
      end
    endcase
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("ack", 32'(ack), 32'(exp_ack));
    check("lcd_we", 32'(lcd_we), 32'(exp_we));
    check("lcd_location", 32'(lcd_location), 32'(exp_loc));
    check("lcd_data", 32'(lcd_data), 32'(exp_data));
    check("lock_timeout", 32'(lock_timeout), 32'(exp_to));
    if (exp_ack != '0) check("rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  // Inputs are set at a falling edge; the model and DUT advance on the next rising edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_ack(input int i, input int budget);
    int b = 0;
    while (!exp_ack[i] && b < budget) begin step(); b++; end
    if (!exp_ack[i]) check("ack_wait", 32'(ack[i]), 32'(1));
  endtask

  task automatic drain();
    req = '0; lock = '0; we = '0;
    repeat (4) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  int           order [$];
  logic [N-1:0] restore, prev_gnt, pending;
  int           n, g0_early;

  initial begin
    rst = 1'b1; mem_load = 1'b1;
    req = '0; we = '0; lock = '0;
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; wdata_a[i] = '0; end
    for (int i = 0; i < 32; i++) ref_mem[i] = seed_val(i);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    mem_load = 1'b0;
    rst = 1'b0;

    // Single write from requester 1.
    req = 3'b010; we = 3'b010; addr_a[1] = 5'd17; wdata_a[1] = 8'h41;
    step();
    check("wr_lcd_we", 32'(lcd_we), 32'd1);
    check("wr_loc", 32'(lcd_location), 32'd17);
    check("wr_data", 32'(lcd_data), 32'h41);
    check("wr_gnt", 32'(gnt), 32'b010);
    step();
    check("wr_ack", 32'(ack), 32'b010);
    check("wr_we_drop", 32'(lcd_we), 32'd0);
    req = '0; we = '0;
    step();
    check("wr_gnt_clr", 32'(gnt), 32'd0);

    // Read of the preloaded cell 3 by requester 0.
    req = 3'b001; addr_a[0] = 5'd3;
    step();
    check("rd_lcd_we", 32'(lcd_we), 32'd0);
    step();
    check("rd_ack", 32'(ack), 32'b001);
    check("rd_data", 32'(rdata), 32'h5A);
    drain();

    // Round-robin under full contention.
    do_reset();
    restore = '0; prev_gnt = '0; req = 3'b111; we = '0; lock = '0;
    for (int i = 0; i < N; i++) addr_a[i] = 5'(i + 8);
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      req = req | restore; restore = '0;
      step();
      if (gnt != '0 && prev_gnt == '0)
        for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
      prev_gnt = gnt;
      for (int i = 0; i < N; i++) if (exp_ack[i]) begin req[i] = 1'b0; restore[i] = 1'b1; end
    end
    check("rr_count", 32'(order.size()), 32'd6);
    for (int k = 0; k < order.size() && k < 6; k++) check("rr_order", 32'(order[k]), 32'(k % 3));
    drain();

    // Locked 16-character line write by requester 2 while requester 0 waits.
    g0_early = 0;
    req = 3'b100; we = 3'b100; lock = 3'b100; addr_a[2] = 5'd0; wdata_a[2] = 8'h41;
    step();
    req[0] = 1'b1; we[0] = 1'b0; addr_a[0] = 5'd20;
    for (int k = 0; k < LCD_LINE_LEN; k++) begin
      addr_a[2] = 5'(k); wdata_a[2] = 8'(8'h41 + k);
      for (int b = 0; b < 10 && !exp_ack[2]; b++) begin
        step();
        if (gnt[0]) g0_early++;
      end
      if (!exp_ack[2]) check("burst_ack", 32'(ack[2]), 32'd1);
      if (k == LCD_LINE_LEN - 1) begin req[2] = 1'b0; lock[2] = 1'b0; we[2] = 1'b0; end
      else step();
      if (gnt[0]) g0_early++;
    end
    check("burst_no_g0", 32'(g0_early), 32'd0);
    n = 0;
    while (!gnt[0] && n < 8) begin step(); n++; end
    check("burst_g0_lat", 32'(n), 32'd2);
    wait_ack(0, 6);
    drain();
    for (int k = 0; k < LCD_LINE_LEN; k++) check("burst_cell", 32'(lcd_mem[k]), 32'(8'h41 + k));

    // Lock timeout: requester 1 keeps lock without requesting; requester 2 waits.
    req = 3'b010; we = 3'b010; lock = 3'b010; addr_a[1] = 5'd25; wdata_a[1] = 8'h77;
    wait_ack(1, 6);
    req = 3'b100; we = '0; addr_a[2] = 5'd30;
    n = 0;
    while (!lock_timeout && n < 20) begin step(); n++; end
    check("to_cycles", 32'(n), 32'd9);
    lock = '0;
    step();
    check("to_gnt2", 32'(gnt), 32'b100);
    drain();

    // Asynchronous reset in the middle of an ISSUE cycle.
    req = 3'b111; we = 3'b111; lock = '0;
    for (int i = 0; i < N; i++) begin addr_a[i] = 5'(i); wdata_a[i] = 8'(8'hC0 + i); end
    step();
    check("ar_pre_we", 32'(lcd_we), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("ar_we", 32'(lcd_we), 32'd0);
    check("ar_gnt", 32'(gnt), 32'd0);
    check("ar_ack", 32'(ack), 32'd0);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    step();
    check("ar_win0", 32'(gnt), 32'b001);
    drain();

    // Random traffic with locks, withdrawals and timeouts.
    pending = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (exp_ack[i]) begin
          pending[i] = 1'b0; req[i] = 1'b0;
          if ($urandom_range(3) == 0) lock[i] = 1'b0;
        end else if (!pending[i] && $urandom_range(4) == 0) begin
          pending[i] = 1'b1; req[i] = 1'b1;
          we[i] = 1'($urandom_range(1));
          addr_a[i] = 5'($urandom_range(31));
          wdata_a[i] = 8'($urandom_range(255));
          lock[i] = ($urandom_range(2) == 0);
        end else if (!pending[i] && $urandom_range(7) == 0) begin
          lock[i] = 1'b0;
        end else if (pending[i] && $urandom_range(31) == 0) begin
          pending[i] = 1'b0; req[i] = 1'b0;
        end
      end
      step();
    end
    drain();
    for (int i = 0; i < 32; i++) check("final_cell", 32'(lcd_mem[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
